// File: rtl/ram_burst_read_arbiter.sv
// Round-robin burst-read arbiter sharing one ram read port between NUM_REQ requesters.
// Returned words are routed back to their owner through a tag pipeline matched to RAM_LATENCY.
module ram_burst_read_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 10,
    parameter int LEN_WIDTH   = 8,
    parameter int RAM_LATENCY = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
    output logic                            ram_read_req,
    output logic [ADDR_WIDTH-1:0]           ram_read_addr,
    input  logic [DATA_WIDTH-1:0]           ram_read_data,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            rsp_last,
    output logic                            busy
);

    // state | meaning
    // IDLE  | arbitrating; accepts the round-robin winner
    // BURST | one ram read per cycle until the burst counter reaches zero
    typedef enum logic {IDLE, BURST} state_t;

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                 state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       owner_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LEN_WIDTH-1:0]   cnt_q;

    logic                   found;
    logic [IDX_W-1:0]       win;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       ptr_nxt;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LEN_WIDTH-1:0]   sel_len;
    logic                   last_read;

    logic [RAM_LATENCY-1:0] tv_q;
    logic [RAM_LATENCY-1:0] tl_q;
    logic [IDX_W-1:0]       to_q [RAM_LATENCY];

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == IDX_W'(k)) begin
                sel_addr = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = req_len[k*LEN_WIDTH +: LEN_WIDTH];
            end
        end
    end

    assign ptr_nxt   = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign last_read = (cnt_q == '0);

    // Grant is held low while reset is asserted so nothing is offered to requesters.
    always_comb begin
        req_ready = '0;
        if (reset && state_q == IDLE && found)
            req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        owner_q <= win;
                        addr_q  <= sel_addr;
                        cnt_q   <= sel_len;
                        ptr_q   <= ptr_nxt;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    addr_q <= addr_q + 1'b1;
                    cnt_q  <= cnt_q - 1'b1;
                    if (last_read)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_read_req  = (state_q == BURST);
    assign ram_read_addr = addr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tv_q <= '0;
            tl_q <= '0;
            for (int s = 0; s < RAM_LATENCY; s++)
                to_q[s] <= '0;
        end else begin
            tv_q[0] <= ram_read_req;
            tl_q[0] <= last_read;
            to_q[0] <= owner_q;
            for (int s = 1; s < RAM_LATENCY; s++) begin
                tv_q[s] <= tv_q[s-1];
                tl_q[s] <= tl_q[s-1];
                to_q[s] <= to_q[s-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (tv_q[RAM_LATENCY-1])
            rsp_valid[to_q[RAM_LATENCY-1]] = 1'b1;
    end

    assign rsp_last = tv_q[RAM_LATENCY-1] & tl_q[RAM_LATENCY-1];
    assign rsp_data = ram_read_data;
    assign busy     = (state_q == BURST) | (|tv_q);

endmodule

// File: tb/tb_ram_burst_read_arbiter.sv
// Bench for ram_burst_read_arbiter: three instances (ram latency 1, 2, 4) share one stimulus
// and are checked every cycle against a schedule-based model, plus directed burst scenarios.
module tb_ram_burst_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 10;
    localparam int LW = 8;
    localparam int LAT [3] = '{1, 2, 4};
    localparam int RING = 1024;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*LW-1:0]   req_len;

    logic [N-1:0]      rdy   [3];
    logic              rreq  [3];
    logic [AW-1:0]     raddr [3];
    logic [DW-1:0]     rdata [3];
    logic [N-1:0]      rsp_v [3];
    logic [DW-1:0]     rsp_d [3];
    logic              rsp_l [3];
    logic              bsy   [3];
    logic [AW-1:0]     rp    [3][4];

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ram_burst_read_arbiter #(
            .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
            .RAM_LATENCY(LAT[g])
        ) u_dut (
            .clk(clk), .reset(rst_n),
            .req_valid(req_valid), .req_ready(rdy[g]),
            .req_addr(req_addr), .req_len(req_len),
            .ram_read_req(rreq[g]), .ram_read_addr(raddr[g]), .ram_read_data(rdata[g]),
            .rsp_valid(rsp_v[g]), .rsp_data(rsp_d[g]), .rsp_last(rsp_l[g]), .busy(bsy[g])
        );
        // ram preloaded with mem[a] = a[9:0]
        assign rdata[g] = rp[g][LAT[g]-1][DW-1:0];
    end

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            rp[d][0] <= raddr[d];
            for (int s = 1; s < 4; s++)
                rp[d][s] <= rp[d][s-1];
        end
    end

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            if (nerr <= 40)
                $display("FAIL %s lat%0d got=%0h want=%0h cyc=%0d", nm, LAT[d], act, exp, cyc);
        end
    endtask

    // Reference model: every accepted burst is expanded into a per-cycle read schedule.
    bit        mv [RING];
    bit [11:0] ma [RING];
    int        mo [RING];
    bit        ml [RING];
    int        ptr_m   = 0;
    int        free_at = 0;

    always @(negedge clk) begin : model
        logic [3:0]  er;
        logic [3:0]  ev_v;
        logic [11:0] base;
        int          w, len, s, m, j, lat;
        bit          ev, bz;
        if (!rst_n) begin
            for (int i = 0; i < RING; i++) mv[i] = 1'b0;
            ptr_m   = 0;
            free_at = cyc + 1;
            for (int d = 0; d < 3; d++) begin
                chk("rst_ready", d, rdy[d], 0);
                chk("rst_rreq",  d, rreq[d], 0);
                chk("rst_raddr", d, raddr[d], 0);
                chk("rst_rspv",  d, rsp_v[d], 0);
                chk("rst_last",  d, rsp_l[d], 0);
                chk("rst_busy",  d, bsy[d], 0);
            end
        end else begin
            er = '0;
            if (cyc >= free_at) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    j = (ptr_m + k) % N;
                    if (w < 0 && req_valid[j]) w = j;
                end
                if (w >= 0) begin
                    er[w] = 1'b1;
                    base  = req_addr[w*AW +: AW];
                    len   = int'(req_len[w*LW +: LW]);
                    for (int b = 0; b <= len; b++) begin
                        s = (cyc + 1 + b) % RING;
                        mv[s] = 1'b1;
                        ma[s] = 12'(int'(base) + b);
                        mo[s] = w;
                        ml[s] = (b == len);
                    end
                    free_at = cyc + 2 + len;
                    ptr_m   = (w + 1) % N;
                end
            end
            s = cyc % RING;
            for (int d = 0; d < 3; d++) begin
                lat = LAT[d];
                chk("ready", d, rdy[d], er);
                chk("rreq", d, rreq[d], mv[s]);
                if (mv[s]) chk("raddr", d, raddr[d], ma[s]);
                m    = (cyc - lat + RING) % RING;
                ev   = mv[m];
                ev_v = ev ? (4'b0001 << mo[m]) : 4'b0000;
                chk("rsp_valid", d, rsp_v[d], ev_v);
                chk("rsp_last", d, rsp_l[d], ev && ml[m]);
                if (ev) chk("rsp_data", d, rsp_d[d], ma[m][9:0]);
                bz = mv[s];
                for (int k = 1; k <= lat; k++) bz = bz | mv[(cyc - k + RING) % RING];
                chk("busy", d, bsy[d], bz);
            end
            mv[(cyc - 6 + RING) % RING] = 1'b0;
        end
        cyc++;
    end

    task automatic set_req(input int r, input logic [11:0] a, input logic [7:0] l);
        req_addr[r*AW +: AW] = a;
        req_len[r*LW +: LW]  = l;
    endtask

    task automatic wait_quiet();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!bsy[0] && !bsy[1] && !bsy[2]) return;
        end
        chk("quiet_timeout", 0, 1, 0);
    endtask

    typedef struct {
        int          r;
        logic [11:0] addr;
        logic [7:0]  len;
        logic [11:0] first_a;
        logic [11:0] last_a;
        int          words;
        logic [3:0]  onehot;
    } vec_t;

    task automatic run_table();
        vec_t tbl [4];
        tbl[0] = '{0, 12'h100, 8'd3,   12'h100, 12'h103, 4,   4'b0001};
        tbl[1] = '{2, 12'hFFE, 8'd3,   12'hFFE, 12'h001, 4,   4'b0100};
        tbl[2] = '{1, 12'h055, 8'd0,   12'h055, 12'h055, 1,   4'b0010};
        tbl[3] = '{3, 12'hF80, 8'd255, 12'hF80, 12'h07F, 256, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            int first_a = -1, last_a = -1, nrd = 0, nrsp = 0, first_rd = -1;
            int first_rsp = -1, nlast = 0, bad_route = 0, last_ok = 0;
            wait_quiet();
            @(posedge clk); #1;
            req_valid = '0;
            req_valid[tbl[i].r] = 1'b1;
            set_req(tbl[i].r, tbl[i].addr, tbl[i].len);
            @(negedge clk);
            chk("tbl_accept", 0, rdy[0], tbl[i].onehot);
            for (int k = 1; k <= tbl[i].words + 8; k++) begin
                @(posedge clk); #1;
                req_valid = '0;
                set_req(tbl[i].r, 12'h5A5, 8'd9);
                @(negedge clk);
                if (rreq[0]) begin
                    if (nrd == 0) begin first_rd = k; first_a = int'(raddr[0]); end
                    last_a = int'(raddr[0]);
                    nrd++;
                end
                if (rsp_v[0] != '0) begin
                    if (nrsp == 0) first_rsp = k;
                    if (rsp_v[0] != tbl[i].onehot) bad_route++;
                    nrsp++;
                    if (rsp_l[0]) begin
                        nlast++;
                        last_ok = (nrsp == tbl[i].words) ? 1 : 0;
                    end
                end
            end
            chk("tbl_nreads", 0, nrd, tbl[i].words);
            chk("tbl_first_addr", 0, first_a, tbl[i].first_a);
            chk("tbl_last_addr", 0, last_a, tbl[i].last_a);
            chk("tbl_first_read_ofs", 0, first_rd, 1);
            chk("tbl_nrsp", 0, nrsp, tbl[i].words);
            chk("tbl_first_rsp_ofs", 0, first_rsp, 2);
            chk("tbl_route", 0, bad_route, 0);
            chk("tbl_nlast", 0, nlast, 1);
            chk("tbl_last_on_final", 0, last_ok, 1);
        end
    endtask

    task automatic run_rr();
        int gidx [5];
        int gcyc [5];
        int ng = 0;
        @(posedge clk); #1;
        for (int r = 0; r < N; r++) set_req(r, 12'(r * 16), 8'd0);
        req_valid = 4'hF;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rdy[0] != '0 && ng < 5) begin
                for (int r = 0; r < N; r++) if (rdy[0][r]) gidx[ng] = r;
                gcyc[ng] = k;
                ng++;
            end
            @(posedge clk); #1;
            if (ng >= 5) begin
                req_valid = '0;
                break;
            end
        end
        chk("rr_count", 0, ng, 5);
        for (int g = 0; g < ng; g++) begin
            chk("rr_owner", 0, gidx[g], g % 4);
            if (g > 0) chk("rr_gap", 0, gcyc[g] - gcyc[g-1], 2);
        end
        req_valid = '0;
    endtask

    task automatic run_reset_mid();
        int nrd = 0;
        int nv  = 0;
        int nb  = 0;
        wait_quiet();
        @(posedge clk); #1;
        req_valid = '0;
        req_valid[1] = 1'b1;
        set_req(1, 12'h010, 8'd7);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rreq[0]) nrd++;
            @(posedge clk); #1;
            req_valid = '0;
            if (nrd == 3) break;
        end
        chk("rmb_reads_before", 0, nrd, 3);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rmb_rreq", d, rreq[d], 0);
            chk("rmb_raddr", d, raddr[d], 0);
            chk("rmb_rspv", d, rsp_v[d], 0);
            chk("rmb_busy", d, bsy[d], 0);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rsp_v[d] != '0) nv++;
                if (bsy[d]) nb++;
            end
        end
        chk("rmb_no_rsp_after", 0, nv, 0);
        chk("rmb_idle_after", 0, nb, 0);
    endtask

    task automatic run_lat();
        int lastrd [3] = '{-1, -1, -1};
        int lastbz [3] = '{-1, -1, -1};
        int cnt0 [3] = '{0, 0, 0};
        int cnt3 [3] = '{0, 0, 0};
        int ovl  [3] = '{0, 0, 0};
        bit dr0 = 1'b0, dr3 = 1'b0;
        @(posedge clk); #1;
        set_req(0, 12'h200, 8'd1);
        set_req(3, 12'h300, 8'd1);
        req_valid = 4'b1001;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (rreq[d]) lastrd[d] = k;
                if (bsy[d]) lastbz[d] = k;
                if ($countones(rsp_v[d]) > 1) ovl[d]++;
                if (rsp_v[d][0]) cnt0[d]++;
                if (rsp_v[d][3]) cnt3[d]++;
            end
            if (rdy[0][0]) dr0 = 1'b1;
            if (rdy[0][3]) dr3 = 1'b1;
            @(posedge clk); #1;
            if (dr0) req_valid[0] = 1'b0;
            if (dr3) req_valid[3] = 1'b0;
        end
        for (int d = 0; d < 3; d++) begin
            chk("lat_r0_words", d, cnt0[d], 2);
            chk("lat_r3_words", d, cnt3[d], 2);
            chk("lat_overlap", d, ovl[d], 0);
            chk("lat_last_read", d, lastrd[d], 5);
            chk("lat_busy_fall", d, lastbz[d] - lastrd[d], LAT[d]);
        end
        req_valid = '0;
    endtask

    task automatic run_random();
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            for (int r = 0; r < N; r++) begin
                req_valid[r] = ($urandom_range(0, 9) < 4);
                set_req(r, 12'($urandom),
                        ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 60))
                                                     : 8'($urandom_range(0, 5)));
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        wait_quiet();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b0010;
        req_addr  = '0;
        req_len   = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready_gated", 0, rdy[0], 0);
        req_valid = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        run_rr();
        run_table();
        run_reset_mid();
        run_lat();
        run_random();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
